// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: default bus widths,
// the wait-counter width and the access FSM state encoding.
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 13;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int WAIT_CNT_WIDTH     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts a single read or write request from the
// datapath, runs it against external memory with a fixed number of wait
// states and reports completion with a one-cycle ready pulse. Every output
// comes from a register or is decoded from the state register, so nothing
// on the req_* inputs reaches the mem_* outputs combinationally.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] req_rdata,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      write_q, write_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;

  // Next-state logic: latch a request in IDLE, count wait states in ACCESS,
  // capture read data on the way out of ACCESS, pulse ready in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_read && req_write) begin
          err_d = 1'b1;
        end else if (req_read || req_write) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!write_q) begin
            rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_cs    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == DONE);
  assign req_rdata = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: one instance with two wait states (A) and
// one with zero wait states (B) share the request inputs, each looks up a
// shared memory array, and both are compared every cycle against a
// transaction-level reference model.
module tb_mem_access_unit;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] memVal;
    logic [DW-1:0] expRdata;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          reqRead;
  logic          reqWrite;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;

  logic [DW-1:0] rdataA, rdataB, memWdataA, memWdataB, memRdataA, memRdataB;
  logic [AW-1:0] memAddrA, memAddrB;
  logic          readyA, readyB, busyA, busyB, errA, errB, csA, csB, weA, weB;

  logic [DW-1:0] memArr [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;
  int readyCntA = 0;
  int readyCntB = 0;

  // Reference model state per instance: cycles left in the transaction
  // (ACCESS cycles plus the DONE cycle), latched request and results.
  int            left   [2] = '{0, 0};
  logic          isWr   [2] = '{1'b0, 1'b0};
  logic [AW-1:0] mAddr  [2] = '{'0, '0};
  logic [DW-1:0] mWdata [2] = '{'0, '0};
  logic [DW-1:0] mRdata [2] = '{'0, '0};
  logic          mErr   [2] = '{1'b0, 1'b0};

  assign memRdataA = memArr[memAddrA];
  assign memRdataB = memArr[memAddrB];

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_A)) dutA (
    .clk(clk), .rst(rst), .req_read(reqRead), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_rdata(rdataA),
    .req_ready(readyA), .busy(busyA), .err(errA), .mem_addr(memAddrA),
    .mem_wdata(memWdataA), .mem_rdata(memRdataA), .mem_cs(csA), .mem_we(weA)
  );

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_B)) dutB (
    .clk(clk), .rst(rst), .req_read(reqRead), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_rdata(rdataB),
    .req_ready(readyB), .busy(busyB), .err(errB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_rdata(memRdataB), .mem_cs(csB), .mem_we(weB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsOf(input int d);
    return (d == 0) ? WS_A : WS_B;
  endfunction

  // Transaction model: an accepted request occupies WAIT_STATES+1 access
  // cycles and one ready cycle; read data is taken from memory as the last
  // access cycle ends.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        left[d]   <= 0;
        isWr[d]   <= 1'b0;
        mAddr[d]  <= '0;
        mWdata[d] <= '0;
        mRdata[d] <= '0;
        mErr[d]   <= 1'b0;
      end else if (left[d] > 0) begin
        mErr[d] <= 1'b0;
        left[d] <= left[d] - 1;
        if (left[d] == 2 && !isWr[d]) mRdata[d] <= memArr[mAddr[d]];
      end else begin
        mErr[d] <= reqRead && reqWrite;
        if (reqRead != reqWrite) begin
          isWr[d]   <= reqWrite;
          mAddr[d]  <= reqAddr;
          mWdata[d] <= reqWdata;
          left[d]   <= wsOf(d) + 2;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input int d, input logic busy, input logic ready, input logic err,
                          input logic cs, input logic we, input logic [AW-1:0] ma,
                          input logic [DW-1:0] mw, input logic [DW-1:0] rd);
    string p;
    p = (d == 0) ? "A" : "B";
    checkOutput({p, ".busy"},      32'(busy),  32'(left[d] > 0));
    checkOutput({p, ".req_ready"}, 32'(ready), 32'(left[d] == 1));
    checkOutput({p, ".err"},       32'(err),   32'(mErr[d]));
    checkOutput({p, ".mem_cs"},    32'(cs),    32'(left[d] >= 2));
    checkOutput({p, ".mem_we"},    32'(we),    32'((left[d] >= 2) && isWr[d]));
    checkOutput({p, ".mem_addr"},  32'(ma),    32'(mAddr[d]));
    checkOutput({p, ".mem_wdata"}, 32'(mw),    32'(mWdata[d]));
    checkOutput({p, ".req_rdata"}, 32'(rd),    32'(mRdata[d]));
  endtask

  // Cycle-by-cycle comparison of both instances against the model, plus
  // free-running ready-pulse counters used by the hand-written sequences.
  always @(negedge clk) begin
    if (chkEn) begin
      checkDut(0, busyA, readyA, errA, csA, weA, memAddrA, memWdataA, rdataA);
      checkDut(1, busyB, readyB, errB, csB, weB, memAddrB, memWdataB, rdataB);
    end
    if (readyA) readyCntA++;
    if (readyB) readyCntB++;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    @(negedge clk);
    reqRead  = rd;
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = wdata;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents one request for a single edge and watches 12 cycles for the
  // ready pulses, chip-select/write-enable cycles and error pulses.
  task automatic runVec(input vec_t v, output int latA, output int latB,
                        output int csCnt, output int weCnt, output int errCnt);
    latA = -1; latB = -1; csCnt = 0; weCnt = 0; errCnt = 0;
    memArr[v.addr] = v.memVal;
    applyStimulus(v.rd, v.wr, v.addr, v.wdata);
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 12; k++) begin
      if (readyA && latA < 0) latA = k;
      if (readyB && latB < 0) latB = k;
      if (csA) csCnt++;
      if (weA) weCnt++;
      if (errA) errCnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs [7];
    int   latA, latB, csCnt, weCnt, errCnt, baseA, baseB;
    logic valid;

    vecs[0] = '{1'b1, 1'b0, 13'h00A5, 8'h00, 8'h3C, 8'h3C};
    vecs[1] = '{1'b0, 1'b1, 13'h1FFF, 8'hA7, 8'h55, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 13'h0123, 8'h99, 8'h77, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h81, 8'h81};
    vecs[4] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{1'b0, 1'b1, 13'h00A5, 8'h00, 8'h12, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 13'h0800, 8'h00, 8'h5A, 8'h5A};

    for (int i = 0; i < (1 << AW); i++) memArr[i] = DW'($urandom);

    rst = 1'b0; reqRead = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    @(negedge clk);
    chkEn = 1'b1;
    // Requests offered during reset must be discarded.
    applyStimulus(1'b1, 1'b0, 13'h0ABC, 8'h5C);
    applyStimulus(1'b0, 1'b1, 13'h0ABC, 8'h5C);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("reset.busy",      32'(busyA),     32'd0);
    checkOutput("reset.mem_cs",    32'(csA),       32'd0);
    checkOutput("reset.mem_addr",  32'(memAddrA),  32'd0);
    checkOutput("reset.mem_wdata", 32'(memWdataA), 32'd0);
    checkOutput("reset.req_rdata", 32'(rdataA),    32'd0);
    rst = 1'b1;
    waitCycles(2);

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      runVec(vecs[i], latA, latB, csCnt, weCnt, errCnt);
      valid = vecs[i].rd ^ vecs[i].wr;
      checkOutput($sformatf("vec%0d.latA", i),   32'(latA),   valid ? 32'(WS_A + 2) : 32'hFFFF_FFFF);
      checkOutput($sformatf("vec%0d.latB", i),   32'(latB),   valid ? 32'(WS_B + 2) : 32'hFFFF_FFFF);
      checkOutput($sformatf("vec%0d.csCnt", i),  32'(csCnt),  valid ? 32'(WS_A + 1) : 32'd0);
      checkOutput($sformatf("vec%0d.weCnt", i),  32'(weCnt),  (valid && vecs[i].wr) ? 32'(WS_A + 1) : 32'd0);
      checkOutput($sformatf("vec%0d.errCnt", i), 32'(errCnt), (vecs[i].rd && vecs[i].wr) ? 32'd1 : 32'd0);
      checkOutput($sformatf("vec%0d.rdataA", i), 32'(rdataA), 32'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d.rdataB", i), 32'(rdataB), 32'(vecs[i].expRdata));
    end

    // A second read while busy is ignored: exactly one ready pulse each.
    memArr[13'h0010] = 8'h5A;
    memArr[13'h0020] = 8'h6B;
    baseA = readyCntA; baseB = readyCntB;
    applyStimulus(1'b1, 1'b0, 13'h0010, '0);
    applyStimulus(1'b1, 1'b0, 13'h0020, '0);
    applyStimulus(1'b1, 1'b0, 13'h0020, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(10);
    checkOutput("busyIgnore.pulsesA", 32'(readyCntA - baseA), 32'd1);
    checkOutput("busyIgnore.pulsesB", 32'(readyCntB - baseB), 32'd1);
    checkOutput("busyIgnore.rdataA",  32'(rdataA), 32'h5A);
    checkOutput("busyIgnore.rdataB",  32'(rdataB), 32'h5A);

    // Reset in the second ACCESS cycle of instance A aborts the access.
    memArr[13'h0300] = 8'hC3;
    baseA = readyCntA;
    applyStimulus(1'b1, 1'b0, 13'h0300, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("abort.csBefore", 32'(csA), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort.mem_cs",    32'(csA),       32'd0);
    checkOutput("abort.busy",      32'(busyA),     32'd0);
    checkOutput("abort.req_rdata", 32'(rdataA),    32'd0);
    checkOutput("abort.mem_addr",  32'(memAddrA),  32'd0);
    waitCycles(10);
    checkOutput("abort.pulsesA", 32'(readyCntA - baseA), 32'd0);

    // Zero wait states: back-to-back reads, each ready two cycles later.
    memArr[13'h0000] = 8'h11;
    memArr[13'h0001] = 8'h22;
    applyStimulus(1'b1, 1'b0, 13'h0000, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("b2b.ready1c", 32'(readyB), 32'd0);
    @(negedge clk);
    checkOutput("b2b.ready2c", 32'(readyB), 32'd1);
    checkOutput("b2b.rdata1",  32'(rdataB), 32'h11);
    applyStimulus(1'b1, 1'b0, 13'h0001, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("b2b.ready1d", 32'(readyB), 32'd0);
    @(negedge clk);
    checkOutput("b2b.ready2d", 32'(readyB), 32'd1);
    checkOutput("b2b.rdata2",  32'(rdataB), 32'h22);
    waitCycles(8);

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 39) != 0);
      reqRead  = ($urandom_range(0, 2) == 0);
      reqWrite = ($urandom_range(0, 3) == 0);
      reqAddr  = AW'($urandom);
      reqWdata = DW'($urandom);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    waitCycles(10);

    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
